// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad sequencer for the lab calculator.
// Collects operand A, an operator, operand B and '=' from debounced key strobes.
// It then computes A op B and converts the binary result to BCD for the display,
// using a double-dabble converter that handles one result bit per clock.

module calc_key_sequencer #(
  parameter int N_DIG = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [3:0]         key_in,
  output logic [1:0]         mode_arith,
  output logic [8*N_DIG-1:0] disp_bcd,
  output logic               disp_neg,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  // Result width is chosen so that 2*N_DIG decimal digits always fit.
  localparam int RW = (N_DIG == 1) ? 7 : ((N_DIG == 2) ? 14 : 20);
  localparam int OW = 4 * N_DIG;
  localparam int DW = 8 * N_DIG;
  localparam int BW = $clog2(RW + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENT_A   = 3'd1,
    S_ENT_B   = 3'd2,
    S_COMPUTE = 3'd3,
    S_CONVERT = 3'd4,
    S_SHOW    = 3'd5
  } state_t;

  state_t          state_q;
  logic [OW-1:0]   a_bcd;
  logic [OW-1:0]   b_bcd;
  logic [RW-1:0]   a_bin;
  logic [RW-1:0]   b_bin;
  logic [1:0]      a_cnt;
  logic [1:0]      b_cnt;
  logic [RW-1:0]   result;
  logic            neg;
  logic [DW-1:0]   bcd_sr;
  logic [BW-1:0]   bit_cnt;

  logic            is_digit;
  logic            is_op;
  logic            is_eq;
  logic            is_clr;
  logic [1:0]      op_mode;
  logic            a_room;
  logic            b_room;
  logic [OW-1:0]   a_bcd_next;
  logic [OW-1:0]   b_bcd_next;
  logic [OW-1:0]   first_bcd;
  logic [RW-1:0]   a_bin_next;
  logic [RW-1:0]   b_bin_next;
  logic [DW-1:0]   bcd_adj;
  logic [DW-1:0]   bcd_shift;

  // Shift one decimal digit into the least significant nibble.
  function automatic logic [OW-1:0] shift_digit(input logic [OW-1:0] bcd, input logic [3:0] d);
    logic [OW-1:0] t;
    t      = bcd << 4;
    t[3:0] = d;
    return t;
  endfunction

  // Track the binary value of an operand alongside its BCD form.
  function automatic logic [RW-1:0] acc_digit(input logic [RW-1:0] bin, input logic [3:0] d);
    return (bin * RW'(10)) + RW'(d);
  endfunction

  // Operands occupy the low half of the display word.
  function automatic logic [DW-1:0] widen(input logic [OW-1:0] v);
    return {{OW{1'b0}}, v};
  endfunction

  assign is_digit = key_valid && (key_in <= 4'd9);
  assign is_op    = key_valid && (key_in >= 4'd10) && (key_in <= 4'd12);
  assign is_eq    = key_valid && (key_in == 4'd13);
  assign is_clr   = key_valid && (key_in == 4'd14);

  assign a_room     = (a_cnt < 2'(N_DIG));
  assign b_room     = (b_cnt < 2'(N_DIG));
  assign a_bcd_next = shift_digit(a_bcd, key_in);
  assign b_bcd_next = shift_digit(b_bcd, key_in);
  assign first_bcd  = shift_digit('0, key_in);
  assign a_bin_next = acc_digit(a_bin, key_in);
  assign b_bin_next = acc_digit(b_bin, key_in);

  assign state = state_q;

  // Translate operator keys into the arithmetic mode encoding.
  always_comb begin
    op_mode = 2'd0;
    case (key_in)
      4'd11:   op_mode = 2'd1;
      4'd12:   op_mode = 2'd2;
      default: op_mode = 2'd0;
    endcase
  end

  // One double-dabble step: add 3 to BCD nibbles of 5 or more, then shift in the next result bit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 2 * N_DIG; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[DW-2:0], result[RW-1]};
  end

  // Sequencer state machine with registered operands, result and display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_bcd      <= '0;
      b_bcd      <= '0;
      a_bin      <= '0;
      b_bin      <= '0;
      a_cnt      <= '0;
      b_cnt      <= '0;
      result     <= '0;
      neg        <= 1'b0;
      bcd_sr     <= '0;
      bit_cnt    <= '0;
      mode_arith <= 2'd0;
      disp_bcd   <= '0;
      disp_neg   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (is_clr) begin
        state_q  <= S_IDLE;
        a_bcd    <= '0;
        b_bcd    <= '0;
        a_bin    <= '0;
        b_bin    <= '0;
        a_cnt    <= '0;
        b_cnt    <= '0;
        result   <= '0;
        neg      <= 1'b0;
        bcd_sr   <= '0;
        bit_cnt  <= '0;
        disp_bcd <= '0;
        disp_neg <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (is_digit) begin
              a_bcd    <= first_bcd;
              a_bin    <= RW'(key_in);
              a_cnt    <= 2'd1;
              disp_bcd <= widen(first_bcd);
              disp_neg <= 1'b0;
              state_q  <= S_ENT_A;
            end else if (is_op) begin
              mode_arith <= op_mode;
              a_bcd      <= '0;
              a_bin      <= '0;
              a_cnt      <= '0;
              b_bcd      <= '0;
              b_bin      <= '0;
              b_cnt      <= '0;
              disp_bcd   <= '0;
              state_q    <= S_ENT_B;
            end
          end

          S_ENT_A: begin
            if (is_digit) begin
              if (a_room) begin
                a_bcd    <= a_bcd_next;
                a_bin    <= a_bin_next;
                a_cnt    <= a_cnt + 2'd1;
                disp_bcd <= widen(a_bcd_next);
              end
            end else if (is_op) begin
              mode_arith <= op_mode;
              b_bcd      <= '0;
              b_bin      <= '0;
              b_cnt      <= '0;
              disp_bcd   <= '0;
              state_q    <= S_ENT_B;
            end
          end

          S_ENT_B: begin
            if (is_digit) begin
              if (b_room) begin
                b_bcd    <= b_bcd_next;
                b_bin    <= b_bin_next;
                b_cnt    <= b_cnt + 2'd1;
                disp_bcd <= widen(b_bcd_next);
              end
            end else if (is_op) begin
              // The operator can still be changed until the first B digit arrives.
              if (b_cnt == 2'd0) begin
                mode_arith <= op_mode;
              end
            end else if (is_eq) begin
              busy    <= 1'b1;
              state_q <= S_COMPUTE;
            end
          end

          S_COMPUTE: begin
            case (mode_arith)
              2'd0: begin
                result <= a_bin + b_bin;
                neg    <= 1'b0;
              end
              2'd1: begin
                if (a_bin >= b_bin) begin
                  result <= a_bin - b_bin;
                  neg    <= 1'b0;
                end else begin
                  result <= b_bin - a_bin;
                  neg    <= 1'b1;
                end
              end
              default: begin
                result <= a_bin * b_bin;
                neg    <= 1'b0;
              end
            endcase
            bcd_sr  <= '0;
            bit_cnt <= '0;
            state_q <= S_CONVERT;
          end

          S_CONVERT: begin
            bcd_sr  <= bcd_shift;
            result  <= result << 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(RW - 1)) begin
              disp_bcd <= bcd_shift;
              disp_neg <= neg;
              busy     <= 1'b0;
              done     <= 1'b1;
              state_q  <= S_SHOW;
            end
          end

          S_SHOW: begin
            if (is_digit) begin
              a_bcd    <= first_bcd;
              a_bin    <= RW'(key_in);
              a_cnt    <= 2'd1;
              b_bcd    <= '0;
              b_bin    <= '0;
              b_cnt    <= '0;
              disp_bcd <= widen(first_bcd);
              disp_neg <= 1'b0;
              state_q  <= S_ENT_A;
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: directed key sequences for the calculator sequencer.
// Each '=' that should finish pushes its expected display onto a queue.
// The monitor pops that entry on every done pulse and checks it.

module tb_calc_key_sequencer;

  localparam int N_DIG = 2;
  localparam int RW    = 14;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               key_valid = 1'b0;
  logic [3:0]         key_in = 4'd0;
  logic [1:0]         mode_arith;
  logic [8*N_DIG-1:0] disp_bcd;
  logic               disp_neg;
  logic               busy;
  logic               done;
  logic [2:0]         state;

  typedef struct {
    logic [15:0] disp;
    logic        neg;
    logic [1:0]  mode;
    int          mark;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   busy_run = 0;

  calc_key_sequencer #(.N_DIG(N_DIG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .mode_arith (mode_arith),
    .disp_bcd   (disp_bcd),
    .disp_neg   (disp_neg),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time the done pulse.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Present one key for exactly one sampling edge; called and returns on a negedge.
  task automatic apply_stimulus(input logic [3:0] k);
    key_valid = 1'b1;
    key_in    = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_in    = 4'd0;
  endtask

  task automatic press_equals(input logic [15:0] disp, input logic neg, input logic [1:0] mode);
    exp_t e;
    e.disp = disp;
    e.neg  = neg;
    e.mode = mode;
    e.mark = cyc;
    exp_q.push_back(e);
    apply_stimulus(4'd13);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(state), 32'(target));
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_disp_bcd", 32'(disp_bcd), 32'(e.disp));
          check_output("sb_disp_neg", 32'(disp_neg), 32'(e.neg));
          check_output("sb_mode", 32'(mode_arith), 32'(e.mode));
          // Counting the edge that samples '=' as the first, done appears on edge RW+2.
          check_output("sb_latency", 32'(cyc - e.mark), 32'(RW + 2));
          check_output("sb_busy_cycles", 32'(busy_run), 32'(RW + 1));
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end else begin
        busy_run = 0;
      end
    end
  end

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int seen;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_disp", 32'(disp_bcd), 32'd0);
    check_output("rst_neg", 32'(disp_neg), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_mode", 32'(mode_arith), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // '=' in IDLE is ignored; operator in IDLE starts B with A=0
    apply_stimulus(4'd13);
    check_output("idle_eq_ignored", 32'(state), 32'd0);
    apply_stimulus(4'd12);
    check_output("idle_op_mode", 32'(mode_arith), 32'd2);
    check_output("idle_op_state", 32'(state), 32'd2);
    apply_stimulus(4'd5);
    check_output("idle_op_b_disp", 32'(disp_bcd), 32'h0005);
    press_equals(16'h0000, 1'b0, 2'd2);
    wait_state(3'd5, 40, "zero_mul_show");

    // 12 * 34 = 408
    apply_stimulus(4'd1);
    check_output("t1_state_a", 32'(state), 32'd1);
    check_output("t1_disp_1", 32'(disp_bcd), 32'h0001);
    apply_stimulus(4'd2);
    check_output("t1_disp_12", 32'(disp_bcd), 32'h0012);
    apply_stimulus(4'd12);
    check_output("t1_state_b", 32'(state), 32'd2);
    check_output("t1_disp_b0", 32'(disp_bcd), 32'h0000);
    apply_stimulus(4'd3);
    apply_stimulus(4'd4);
    check_output("t1_disp_34", 32'(disp_bcd), 32'h0034);
    press_equals(16'h0408, 1'b0, 2'd2);
    check_output("t1_compute", 32'(state), 32'd3);
    check_output("t1_busy", 32'(busy), 32'd1);
    wait_state(3'd5, 40, "t1_show");
    check_output("t1_result", 32'(disp_bcd), 32'h0408);

    // 5 - 27 = -22, then a digit starts a new A
    apply_stimulus(4'd5);
    check_output("t2_new_a", 32'(disp_bcd), 32'h0005);
    apply_stimulus(4'd11);
    check_output("t2_mode", 32'(mode_arith), 32'd1);
    apply_stimulus(4'd2);
    apply_stimulus(4'd7);
    press_equals(16'h0022, 1'b1, 2'd1);
    wait_state(3'd5, 40, "t2_show");
    check_output("t2_neg", 32'(disp_neg), 32'd1);
    apply_stimulus(4'd7);
    check_output("t2_after_state", 32'(state), 32'd1);
    check_output("t2_after_disp", 32'(disp_bcd), 32'h0007);
    check_output("t2_after_neg", 32'(disp_neg), 32'd0);
    check_output("t2_after_mode", 32'(mode_arith), 32'd1);

    // Clear, then 12 (3 dropped) + 99 (third 9 dropped) = 111
    apply_stimulus(4'd14);
    check_output("t3_clr_state", 32'(state), 32'd0);
    check_output("t3_clr_disp", 32'(disp_bcd), 32'd0);
    check_output("t3_clr_mode", 32'(mode_arith), 32'd1);
    apply_stimulus(4'd1);
    apply_stimulus(4'd2);
    apply_stimulus(4'd3);
    check_output("t3_a_limit", 32'(disp_bcd), 32'h0012);
    apply_stimulus(4'd10);
    check_output("t3_mode", 32'(mode_arith), 32'd0);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    check_output("t3_b_limit", 32'(disp_bcd), 32'h0099);
    press_equals(16'h0111, 1'b0, 2'd0);
    wait_state(3'd5, 40, "t3_show");

    // 99 * 99 = 9801 with keys dropped during COMPUTE/CONVERT
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    apply_stimulus(4'd12);
    apply_stimulus(4'd9);
    apply_stimulus(4'd9);
    press_equals(16'h9801, 1'b0, 2'd2);
    apply_stimulus(4'd5);
    apply_stimulus(4'd10);
    apply_stimulus(4'd13);
    apply_stimulus(4'd15);
    check_output("t4_still_convert", 32'(state), 32'd4);
    check_output("t4_disp_held", 32'(disp_bcd), 32'h0099);
    wait_state(3'd5, 40, "t4_show");
    check_output("t4_result", 32'(disp_bcd), 32'h9801);

    // 7 + then * overrides before B; - after 4 is ignored; 7*4 = 28
    apply_stimulus(4'd14);
    apply_stimulus(4'd7);
    apply_stimulus(4'd10);
    check_output("t5_mode_add", 32'(mode_arith), 32'd0);
    apply_stimulus(4'd12);
    check_output("t5_override", 32'(mode_arith), 32'd2);
    apply_stimulus(4'd4);
    apply_stimulus(4'd11);
    check_output("t5_no_override", 32'(mode_arith), 32'd2);
    press_equals(16'h0028, 1'b0, 2'd2);
    wait_state(3'd5, 40, "t5_show");

    // '=' then clear five cycles later aborts with no done pulse
    apply_stimulus(4'd14);
    apply_stimulus(4'd3);
    apply_stimulus(4'd11);
    apply_stimulus(4'd1);
    apply_stimulus(4'd13);
    repeat (4) @(negedge clk);
    apply_stimulus(4'd14);
    check_output("t6_abort_state", 32'(state), 32'd0);
    check_output("t6_abort_disp", 32'(disp_bcd), 32'd0);
    check_output("t6_abort_mode", 32'(mode_arith), 32'd1);
    check_output("t6_abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_output("t6_no_done", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of operand B entry
    apply_stimulus(4'd8);
    apply_stimulus(4'd12);
    apply_stimulus(4'd6);
    check_output("t7_pre_state", 32'(state), 32'd2);
    check_output("t7_pre_disp", 32'(disp_bcd), 32'h0006);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t7_async_state", 32'(state), 32'd0);
    check_output("t7_async_disp", 32'(disp_bcd), 32'd0);
    check_output("t7_async_mode", 32'(mode_arith), 32'd0);
    check_output("t7_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(4'd4);
    check_output("t7_post_disp", 32'(disp_bcd), 32'h0004);

    repeat (3) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
